// File: rtl/de1_hex_pkg.sv
// Character codes shared by the scroll driver and the HEX decoders.
// Codes are 2 bits wide: bit 1 feeds S1, bit 0 feeds S0.
package de1_hex_pkg;

    localparam int CODE_W = 2;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_D     = 2'b00;
    localparam code_t CODE_E     = 2'b01;
    localparam code_t CODE_1     = 2'b10;
    localparam code_t CODE_BLANK = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that pauses (holds its count) while disabled
// and emits a registered one-cycle pulse on each wrap.
module tick_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/de1_scroll_driver.sv
// Rotating ring of character codes spelling "dE1" for the HEX decoders,
// advanced by the prescaler tick or by a single-step strobe while paused.
module de1_scroll_driver
    import de1_hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          en,
    input  logic                          dir,
    input  logic                          step,
    output logic [2*NUM_DIGITS-1:0]       digit_codes,
    output logic                          tick,
    output logic [$clog2(NUM_DIGITS)-1:0] pos
);

    localparam int RW = CODE_W * NUM_DIGITS;
    localparam int PW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] POS_MAX = PW'(NUM_DIGITS - 1);

    function automatic logic [RW-1:0] ring_init();
        logic [RW-1:0] r;
        r = {RW{1'b1}};
        r[RW-1 -: CODE_W]            = CODE_D;
        r[RW-1-CODE_W -: CODE_W]     = CODE_E;
        r[RW-1-2*CODE_W -: CODE_W]   = CODE_1;
        return r;
    endfunction

    logic [RW-1:0] ring_q, ring_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          tick_w;
    logic          rot;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .en   (en),
        .tick (tick_w)
    );

    // A step strobe only counts while paused; auto-scroll owns the ring otherwise.
    assign rot = tick_w | (step & ~en);

    always_comb begin
        ring_d = ring_q;
        pos_d  = pos_q;
        if (rot) begin
            if (dir == DIR_RIGHT) begin
                ring_d = {ring_q[CODE_W-1:0], ring_q[RW-1:CODE_W]};
                pos_d  = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
            end else begin
                ring_d = {ring_q[RW-CODE_W-1:0], ring_q[RW-1:RW-CODE_W]};
                pos_d  = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ring_q <= ring_init();
            pos_q  <= '0;
        end else begin
            ring_q <= ring_d;
            pos_q  <= pos_d;
        end
    end

    assign digit_codes = ring_q;
    assign tick        = tick_w;
    assign pos         = pos_q;

endmodule
